// File: rtl/prbs_chk_pkg.sv
// Shared types and helpers for the PRBS-31 checker controller.
package prbs_chk_pkg;

    localparam int PRBS_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEED   = 3'd1,
        SEARCH = 3'd2,
        VERIFY = 3'd3,
        LOCKED = 3'd4,
        RESYNC = 3'd5
    } state_t;

    function automatic logic [4:0] popcount16(input logic [PRBS_W-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < PRBS_W; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/prbs_err_cnt.sv
// Saturating counter with a variable increment and synchronous clear.
module prbs_err_cnt #(
    parameter int CNT_W = 32,
    parameter int INC_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [INC_W-1:0] inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W:0] sum;

    always_comb begin
        sum = {1'b0, cnt} + {{(CNT_W + 1 - INC_W){1'b0}}, inc};
    end

    // A carry out of the top bit means the add overflowed, so clamp at all-ones.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (sum[CNT_W]) begin
            cnt <= '1;
        end else begin
            cnt <= sum[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/prbs31_chk_ctrl.sv
// Control FSM and error accounting for a 16-bit parallel PRBS-31 checker.
// Drives an external generator and compares its output with the RX word stream.
module prbs31_chk_ctrl
    import prbs_chk_pkg::*;
#(
    parameter int LOCK_CNT    = 64,
    parameter int WIN_LEN     = 1024,
    parameter int LOSS_THRESH = 16,
    parameter int CNT_W       = 32
) (
    input  logic              C,
    input  logic              R,
    input  logic              en,
    input  logic              clr_cnt,
    input  logic              rx_valid,
    input  logic [PRBS_W-1:0] rx_data,
    input  logic [PRBS_W-1:0] gen_q,
    output logic              gen_ce,
    output logic              gen_rst,
    output logic              locked,
    output logic              lock_loss_pulse,
    output logic [CNT_W-1:0]  bit_err_cnt,
    output logic [CNT_W-1:0]  word_err_cnt,
    output logic [CNT_W-1:0]  word_cnt,
    output logic [2:0]        state_o
);

    localparam int MW = $clog2(LOCK_CNT);
    localparam int WW = $clog2(WIN_LEN);
    localparam int EW = $clog2(LOSS_THRESH);
    localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_CNT - 1);
    localparam logic [WW-1:0] WIN_LAST  = WW'(WIN_LEN - 1);
    localparam logic [EW-1:0] LOSS_LAST = EW'(LOSS_THRESH - 1);

    state_t        state, next_state;
    logic [MW-1:0] match_cnt;
    logic [WW-1:0] win_cnt;
    logic [EW-1:0] win_err;
    logic          word_eq;
    logic          take;
    logic          count_word;
    logic          err_word;
    logic [4:0]    bit_inc;

    always_comb begin
        word_eq    = (rx_data == gen_q);
        take       = en && rx_valid;
        count_word = take && (state == LOCKED);
        err_word   = count_word && !word_eq;
        bit_inc    = err_word ? popcount16(rx_data ^ gen_q) : 5'd0;
    end

    // In SEARCH the generator stays parked on its seed word until the stream matches it.
    always_comb begin
        next_state = state;
        gen_ce     = 1'b0;
        if (!en) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:   next_state = SEED;
                SEED:   next_state = SEARCH;
                SEARCH: begin
                    gen_ce = rx_valid && word_eq;
                    if (rx_valid && word_eq) next_state = VERIFY;
                end
                VERIFY: begin
                    gen_ce = rx_valid;
                    if (rx_valid && !word_eq)                    next_state = RESYNC;
                    else if (rx_valid && match_cnt == LOCK_LAST) next_state = LOCKED;
                end
                LOCKED: begin
                    gen_ce = rx_valid;
                    if (err_word && win_err == LOSS_LAST) next_state = RESYNC;
                end
                RESYNC:  next_state = SEARCH;
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge C) begin
        if (R) begin
            state           <= IDLE;
            gen_rst         <= 1'b1;
            lock_loss_pulse <= 1'b0;
            match_cnt       <= '0;
            win_cnt         <= '0;
            win_err         <= '0;
        end else begin
            state           <= next_state;
            gen_rst         <= (next_state == IDLE) || (next_state == SEED) || (next_state == RESYNC);
            lock_loss_pulse <= (state == LOCKED) && (next_state == RESYNC);

            if (state == SEARCH && next_state == VERIFY) begin
                match_cnt <= MW'(1);
            end else if (state == VERIFY && take && word_eq) begin
                match_cnt <= match_cnt + MW'(1);
            end

            // The loss window only runs while lock is held; any exit starts it afresh.
            if (state != LOCKED || next_state != LOCKED) begin
                win_cnt <= '0;
                win_err <= '0;
            end else if (count_word) begin
                if (win_cnt == WIN_LAST) begin
                    win_cnt <= '0;
                    win_err <= '0;
                end else begin
                    win_cnt <= win_cnt + WW'(1);
                    if (err_word) win_err <= win_err + EW'(1);
                end
            end
        end
    end

    always_comb begin
        locked  = (state == LOCKED);
        state_o = state;
    end

    prbs_err_cnt #(.CNT_W(CNT_W), .INC_W(5)) u_bit_err (
        .clk (C),
        .rst (R),
        .clr (clr_cnt),
        .inc (bit_inc),
        .cnt (bit_err_cnt)
    );

    prbs_err_cnt #(.CNT_W(CNT_W), .INC_W(1)) u_word_err (
        .clk (C),
        .rst (R),
        .clr (clr_cnt),
        .inc (err_word),
        .cnt (word_err_cnt)
    );

    prbs_err_cnt #(.CNT_W(CNT_W), .INC_W(1)) u_word_cnt (
        .clk (C),
        .rst (R),
        .clr (clr_cnt),
        .inc (count_word),
        .cnt (word_cnt)
    );

endmodule

// File: doc/prbs31_chk_ctrl.md
Name: prbs31_chk_ctrl

Overview:
- Controller for a checker built on the 16-bit parallel PRBS-31 generator (X31+X28+1, XNOR feedback, fixed reset seed).
- Drives the generator's CE and reset and compares its output with received 16-bit words.
- Acquires word alignment, declares lock, counts bit/word errors and re-acquires on loss of lock.
- Sits in the RX latency/PRBS test path between the GTF RX word stream and status/AXI-lite registers.

Parameters:
- LOCK_CNT, 64: consecutive matching words required to move from VERIFY to LOCKED.
- WIN_LEN, 1024: words per loss-of-lock observation window.
- LOSS_THRESH, 16: errored words within one window that force loss of lock.
- CNT_W, 32: width of the error and word counters.

Ports:
- C, in, 1: clock.
- R, in, 1: synchronous active-high reset.
- en, in, 1: checker enable. 0 forces IDLE.
- clr_cnt, in, 1: synchronous clear of all counters. Lock state is unaffected.
- rx_valid, in, 1: rx_data qualifier.
- rx_data, in, 16: received word, MSB first.
- gen_q, in, 16: generator output.
- gen_ce, out, 1: generator clock enable. Combinational.
- gen_rst, out, 1: generator synchronous reset. Registered.
- locked, out, 1: LOCKED state indicator.
- lock_loss_pulse, out, 1: one-cycle pulse on a LOCKED-to-RESYNC transition.
- bit_err_cnt, out, CNT_W: saturating count of errored bits while LOCKED.
- word_err_cnt, out, CNT_W: saturating count of errored words while LOCKED.
- word_cnt, out, CNT_W: saturating count of valid words while LOCKED.
- state_o, out, 3: current state encoding.

Behaviour:
- Clock and reset: single clock C. Reset R is synchronous, active-high, and has priority over every other input.
- Reset values: state=IDLE, gen_rst=1, locked=0, lock_loss_pulse=0, all counters 0. Internal match counter, window counter and window error counter all 0.
- States: IDLE=0, SEED=1, SEARCH=2, VERIFY=3, LOCKED=4, RESYNC=5.
- Generator latency: the generator's output register updates one cycle after gen_ce, so gen_q always corresponds to the next expected word.
- IDLE: gen_rst=1, gen_ce=0. When en=1, go to SEED.
- SEED: gen_rst=1 for exactly one cycle, then go to SEARCH.
- SEARCH: gen_rst=0. The generator is held at its seed word.
  - gen_ce = rx_valid & (rx_data==gen_q).
  - On such a match, clear the match counter to 1 and go to VERIFY.
- VERIFY: gen_ce = rx_valid.
  - Each valid word equal to gen_q increments the match counter. Reaching LOCK_CNT goes to LOCKED.
  - Any valid mismatch goes to RESYNC.
- LOCKED: gen_ce = rx_valid, locked=1. For each valid word:
  - word_cnt += 1.
  - If the word differs from gen_q: word_err_cnt += 1, bit_err_cnt += popcount(rx_data ^ gen_q) (range 0..16), window error counter += 1.
  - Window counter increments per valid word. At WIN_LEN the window counter and window error counter both clear.
  - Window error counter reaching LOSS_THRESH goes to RESYNC and pulses lock_loss_pulse.
- RESYNC: gen_ce=0, gen_rst=1 for one cycle, then go to SEARCH. Counters hold; only clr_cnt or R clears them.
- en=0 in any state: next state IDLE, locked=0 the following cycle, counters hold.
- rx_valid=0: no comparisons and no counting. The generator does not advance, because gen_ce=0.
- Saturation: every counter stops at all-ones, with no wrap. A bit_err_cnt addition that would overflow clamps to all-ones.
- clr_cnt and a count event in the same cycle: the clear wins, leaving the counter at 0.
- R asserted mid-operation: all state returns to the reset values next cycle, including locked=0. No lock_loss_pulse is generated.

Decomposition:
- Package prbs_chk_pkg holds:
  - the state enumeration (3-bit);
  - PRBS_W=16;
  - a popcount16 function.
- One sub-module, prbs_err_cnt, provides the saturating CNT_W counter with increment input and clear. It is instantiated three times.
- The generator is instantiated outside this block.

Test Plan:
- Reset then en=1 with a clean PRBS-31 stream from an identical generator:
  - gen_rst is high through SEED, then SEARCH, VERIFY, and LOCKED after 64 valid words.
  - locked=1 and all error counters stay 0.
- Single word of the locked stream with 3 bits flipped: bit_err_cnt=3, word_err_cnt=1, locked stays 1.
- 16 errored words within 1024: lock_loss_pulse is high for one cycle, the state passes through RESYNC (gen_rst high for one cycle), then returns to SEARCH. 15 errored words in the window: lock is kept.
- Mismatch at the 10th word in VERIFY: RESYNC then SEARCH, and locked never asserts.
- rx_valid toggled 50% during LOCKED: gen_ce equals rx_valid, word_cnt equals the number of valid words, zero errors.
- Counter preloaded near saturation by forcing, plus clr_cnt concurrent with an error:
  - counters hold at all-ones when saturated;
  - the simultaneous clear yields 0;
  - R mid-LOCKED gives IDLE and locked=0 next cycle.
